dcache_read_burst: RTL and testbench
====================================

Name: dcache_read_burst

Overview:
Read-side counterpart of the data cache write path. Accepts one read request (address, length 1–4 bytes, cacheable flag) and issues one Avalon-MM read burst. An uncached read fetches 1 or 2 dwords; a cacheable read fetches a full 4-dword line fill. The block collects the returned beats, extracts the little-endian, byte-aligned result, and returns it with a done pulse. It sits between the dcache control FSM and the memory-side burst master.

Parameters:
none

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
read_do  input  1  request valid; sampled only while read_ready=1
read_address  input  32  byte address of first requested byte
read_length  input  3  bytes requested, 1..4; 0 and 5..7 are illegal, never driven
read_cacheable  input  1  request line fill when the access fits in one 16-byte line
read_ready  output  1  block idle, request accepted this cycle if read_do=1
read_done  output  1  one-cycle pulse; read_data (and read_line if line fill) valid
read_data  output  32  extracted bytes in [8*len-1:0]; upper bytes zero
read_line  output  128  filled line, dword k in [32k+31:32k]
read_line_valid  output  1  high with read_done when a 4-dword line fill was performed
avm_address  output  30  dword address [31:2]
avm_read  output  1  read command
avm_burstcount  output  3  beats: 1, 2 or 4
avm_waitrequest  input  1  slave stall
avm_readdata  input  32  beat data
avm_readdatavalid  input  1  beat valid

Behaviour:
- States: IDLE, ISSUE, DATA, DONE. Reset, or rst in any state, forces IDLE on the next edge.
- Reset values: read_ready=1, read_done=0, read_data=0, read_line=0, read_line_valid=0, avm_read=0, avm_address=0, avm_burstcount=1.
- IDLE: read_ready=1. When read_do=1, latch address, length and mode, then go to ISSUE. Inputs are not sampled outside IDLE.
- Mode selection:
  - Line fill if read_cacheable=1 and address[3:0]+length <= 16.
  - Otherwise uncached.
- Line fill: avm_address = {address[31:4],2'b00}, burstcount=4.
- Uncached: avm_address = address[31:2]. burstcount=2 when (len=2 and a[1:0]=3), (len=3 and a[1]=1), or (len=4 and a[1:0]!=0); otherwise 1.
- ISSUE: avm_read=1, with address and burstcount held stable. Stay while avm_waitrequest=1. On avm_waitrequest=0, drop avm_read next cycle and go to DATA.
- DATA: a 2-bit beat counter starts at 0. Each avm_readdatavalid=1 stores avm_readdata into beat slot[cnt] and increments cnt. After the last beat (cnt = burstcount-1 with valid), go to DONE. Gaps between beats are allowed. avm_readdatavalid is ignored in IDLE, ISSUE and DONE.
- Extraction:
  - Uncached: read_data = ({slot1,slot0} >> 8*a[1:0]), masked to len bytes.
  - Line fill: read_data = (line >> 8*a[3:0]), masked to len bytes. read_line = {slot3,slot2,slot1,slot0}.
- DONE (one cycle): read_done=1; read_line_valid=1 if line fill. Next state is IDLE; read_ready=0 during DONE.
- read_data and read_line hold their values until the next DONE. read_line_valid and read_done are pulses.
- Minimum latency: request accepted at cycle T, avm_read at T+1 (no stall), first beat at T+2 earliest. With a single beat, read_done is at T+3.
- Reset mid-burst: the burst is abandoned; the memory side is reset by the same rst, so no stray beats arrive.

Test Plan:
- Uncached aligned: addr=0x1000, len=4, readdata=0xDDCCBBAA -> burstcount=1, avm_address=0x400, read_data=0xDDCCBBAA, read_done at T+3.
- Uncached split: addr=0x1003, len=4, beats 0x44332211 then 0x88776655 -> burstcount=2, avm_address=0x400, read_data=0x77665544.
- Short read: addr=0x2002, len=2, beat 0xA1B2C3D4 -> burstcount=1, read_data=0x0000A1B2.
- Line fill: addr=0x300C, len=4, cacheable, beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> avm_address=0xC00, burstcount=4, read_line_valid=1, read_line=0x0F0E..0100, read_data=0x0F0E0D0C.
- Cacheable fallback and stalls: addr=0x400E, len=4, cacheable, waitrequest held 3 cycles, 2-cycle gap between beats -> burstcount=2, avm_read held through the stall, read_line_valid=0, one read_done.
- Reset mid-DATA after 1 of 4 beats -> next cycle read_ready=1, avm_read=0, no read_done; a following request completes normally.

Source files
------------

// File: rtl/dcache_read_burst_if.sv
// Bundle of the request/response signals toward the dcache control FSM and
// the Avalon-MM read burst signals toward memory.
// The slave modport is the dcache_read_burst block's view. The master modport
// is the surrounding logic's view: the requester plus the memory side.
// Request handshake: a request moves only in a cycle where read_do=1 and
// read_ready=1 at the same clock edge. read_done marks a single cycle in which
// the result is valid. Nothing acknowledges read_done.
// The avm side follows Avalon-MM rules. avm_read, avm_address and
// avm_burstcount stay stable while avm_waitrequest=1. A beat is accepted at
// each edge where avm_readdatavalid=1.
interface dcache_read_burst_if;
    logic         read_do;
    logic [31:0]  read_address;
    logic [2:0]   read_length;
    logic         read_cacheable;
    logic         read_ready;
    logic         read_done;
    logic [31:0]  read_data;
    logic [127:0] read_line;
    logic         read_line_valid;
    logic [29:0]  avm_address;
    logic         avm_read;
    logic [2:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic [1:0]   debug_state;

    modport slave (
        input  read_do, read_address, read_length, read_cacheable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output read_ready, read_done, read_data, read_line, read_line_valid,
        output avm_address, avm_read, avm_burstcount, debug_state
    );

    modport master (
        output read_do, read_address, read_length, read_cacheable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  read_ready, read_done, read_data, read_line, read_line_valid,
        input  avm_address, avm_read, avm_burstcount, debug_state
    );
endinterface

// File: rtl/dcache_read_burst.sv
// Data cache read path. The block takes one read request and issues one
// Avalon-MM read burst for it. An uncached read uses 1 or 2 beats. A
// cacheable read that fits inside one line uses a 4-beat line fill.
// The block then extracts the little-endian bytes that were requested.
module dcache_read_burst (
    input logic                clk,
    input logic                rst,
    dcache_read_burst_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

    state_t      state;
    logic [3:0]  addr_q;     // only the offset within a line is needed after issue
    logic [2:0]  len_q;
    logic        fill_q;
    logic        split_q;
    logic [1:0]  cnt;
    logic [31:0] slot [4];

    logic [4:0]   line_span;
    logic [3:0]   dword_span;
    logic         fill_req;
    logic         split_req;
    logic [31:0]  slot_next [4];
    logic [127:0] line_next;
    logic [127:0] line_shift;
    logic [63:0]  pair_shift;
    logic [31:0]  raw_data;
    logic [31:0]  len_mask;
    logic [31:0]  data_next;
    logic [1:0]   last_cnt;
    logic         last_beat;

    // Mode decode for the request presented now.
    always_comb begin
        line_span  = {1'b0, bus.read_address[3:0]} + {2'b00, bus.read_length};
        dword_span = {2'b00, bus.read_address[1:0]} + {1'b0, bus.read_length};
        fill_req   = bus.read_cacheable && (line_span <= 5'd16);
        split_req  = !fill_req && (dword_span > 4'd4);
    end

    // Beat slots as they will look after this cycle's beat. This lets the last
    // beat go straight into the registered result.
    always_comb begin
        for (int k = 0; k < 4; k++) slot_next[k] = slot[k];
        if (state == DATA && bus.avm_readdatavalid) slot_next[cnt] = bus.avm_readdata;
        line_next  = {slot_next[3], slot_next[2], slot_next[1], slot_next[0]};
        line_shift = line_next >> {addr_q, 3'b000};
        pair_shift = {slot_next[1], slot_next[0]} >> {addr_q[1:0], 3'b000};
        raw_data   = fill_q ? line_shift[31:0] : pair_shift[31:0];
        case (len_q)
            3'd1:    len_mask = 32'h0000_00FF;
            3'd2:    len_mask = 32'h0000_FFFF;
            3'd3:    len_mask = 32'h00FF_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
        data_next = raw_data & len_mask;
        last_cnt  = fill_q ? 2'd3 : {1'b0, split_q};
        last_beat = (state == DATA) && bus.avm_readdatavalid && (cnt == last_cnt);
    end

    assign bus.debug_state = state;

    // Request, issue and collect state machine. All outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            addr_q              <= '0;
            len_q               <= '0;
            fill_q              <= 1'b0;
            split_q             <= 1'b0;
            cnt                 <= '0;
            for (int k = 0; k < 4; k++) slot[k] <= '0;
            bus.read_ready      <= 1'b1;
            bus.read_done       <= 1'b0;
            bus.read_data       <= '0;
            bus.read_line       <= '0;
            bus.read_line_valid <= 1'b0;
            bus.avm_read        <= 1'b0;
            bus.avm_address     <= '0;
            bus.avm_burstcount  <= 3'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read_do) begin
                        addr_q             <= bus.read_address[3:0];
                        len_q              <= bus.read_length;
                        fill_q             <= fill_req;
                        split_q            <= split_req;
                        cnt                <= '0;
                        bus.avm_address    <= fill_req ? {bus.read_address[31:4], 2'b00}
                                                       : bus.read_address[31:2];
                        bus.avm_burstcount <= fill_req ? 3'd4 : (split_req ? 3'd2 : 3'd1);
                        bus.avm_read       <= 1'b1;
                        bus.read_ready     <= 1'b0;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_read <= 1'b0;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (bus.avm_readdatavalid) begin
                        slot[cnt] <= bus.avm_readdata;
                        cnt       <= cnt + 2'd1;
                    end
                    if (last_beat) begin
                        bus.read_data       <= data_next;
                        if (fill_q) bus.read_line <= line_next;
                        bus.read_line_valid <= fill_q;
                        bus.read_done       <= 1'b1;
                        state               <= DONE;
                    end
                end
                DONE: begin
                    bus.read_done       <= 1'b0;
                    bus.read_line_valid <= 1'b0;
                    bus.read_ready      <= 1'b1;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_read_burst.sv
// Directed bench for dcache_read_burst. The expected values were worked out
// by hand for each vector.
module tb_dcache_read_burst;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dcache_read_burst_if bus();

    dcache_read_burst dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The task is entered at a negedge. It runs one request, its burst and its
    // completion, then leaves at a negedge with the block back in IDLE.
    task automatic do_read(input string name, input logic [31:0] addr, input logic [2:0] len,
                           input logic cach, input int stall, input int gap,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input logic [2:0] exp_bc, input logic [29:0] exp_addr,
                           input logic [31:0] exp_data, input logic exp_lv,
                           input logic [127:0] exp_line);
        logic [31:0] beats [4];
        int n;
        int cyc;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        n = int'(exp_bc);
        check({name, " ready_before"}, bus.read_ready, 1'b1);
        bus.read_do        = 1'b1;
        bus.read_address   = addr;
        bus.read_length    = len;
        bus.read_cacheable = cach;
        @(posedge clk); cyc = 1;
        @(negedge clk);
        bus.read_do = 1'b0;
        check({name, " avm_read"}, bus.avm_read, 1'b1);
        check({name, " burstcount"}, bus.avm_burstcount, exp_bc);
        check({name, " avm_address"}, bus.avm_address, exp_addr);
        check({name, " ready_busy"}, bus.read_ready, 1'b0);
        // The slave stalls here. Junk beats are offered and must not be captured.
        for (int i = 0; i < stall; i++) begin
            bus.avm_waitrequest   = 1'b1;
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = 32'hDEAD_BEEF;
            @(posedge clk); cyc++;
            @(negedge clk);
            check({name, " read_held"}, bus.avm_read, 1'b1);
            check({name, " addr_held"}, bus.avm_address, exp_addr);
        end
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        @(posedge clk); cyc++;
        @(negedge clk);
        check({name, " read_dropped"}, bus.avm_read, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.avm_readdatavalid = 1'b0;
                    bus.avm_readdata      = 32'hBAD0_0BAD;
                    @(posedge clk); cyc++;
                    @(negedge clk);
                    check({name, " no_done_gap"}, bus.read_done, 1'b0);
                end
            end
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = beats[k];
            @(posedge clk); cyc++;
            @(negedge clk);
            bus.avm_readdatavalid = 1'b0;
            if (k < n - 1) check({name, " no_done_early"}, bus.read_done, 1'b0);
        end
        check({name, " done"}, bus.read_done, 1'b1);
        check({name, " latency"}, 128'(cyc), 128'(3 + stall + (n - 1) * (1 + gap)));
        check({name, " data"}, bus.read_data, exp_data);
        check({name, " line_valid"}, bus.read_line_valid, exp_lv);
        check({name, " ready_in_done"}, bus.read_ready, 1'b0);
        if (exp_lv) check({name, " line"}, bus.read_line, exp_line);
        @(posedge clk);
        @(negedge clk);
        check({name, " done_pulse"}, bus.read_done, 1'b0);
        check({name, " lv_pulse"}, bus.read_line_valid, 1'b0);
        check({name, " ready_after"}, bus.read_ready, 1'b1);
        check({name, " data_hold"}, bus.read_data, exp_data);
    endtask

    // Directed stimulus
    initial begin
        checks   = 0;
        failures = 0;
        rst                   = 1'b1;
        bus.read_do           = 1'b0;
        bus.read_address      = '0;
        bus.read_length       = 3'd4;
        bus.read_cacheable    = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", bus.read_ready, 1'b1);
        check("rst done", bus.read_done, 1'b0);
        check("rst data", bus.read_data, 32'h0);
        check("rst line", bus.read_line, 128'h0);
        check("rst lv", bus.read_line_valid, 1'b0);
        check("rst avm_read", bus.avm_read, 1'b0);
        check("rst avm_address", bus.avm_address, 30'h0);
        check("rst burstcount", bus.avm_burstcount, 3'd1);
        rst = 1'b0;
        @(negedge clk);

        do_read("aligned", 32'h1000, 3'd4, 1'b0, 0, 0,
                32'hDDCC_BBAA, 32'h0, 32'h0, 32'h0,
                3'd1, 30'h400, 32'hDDCC_BBAA, 1'b0, 128'h0);
        do_read("split", 32'h1003, 3'd4, 1'b0, 0, 0,
                32'h4433_2211, 32'h8877_6655, 32'h0, 32'h0,
                3'd2, 30'h400, 32'h7766_5544, 1'b0, 128'h0);
        do_read("short", 32'h2002, 3'd2, 1'b0, 0, 0,
                32'hA1B2_C3D4, 32'h0, 32'h0, 32'h0,
                3'd1, 30'h800, 32'h0000_A1B2, 1'b0, 128'h0);
        do_read("fill", 32'h300C, 3'd4, 1'b1, 0, 0,
                32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C,
                3'd4, 30'hC00, 32'h0F0E_0D0C, 1'b1,
                128'h0F0E0D0C_0B0A0908_07060504_03020100);
        do_read("fallback", 32'h400E, 3'd4, 1'b1, 3, 2,
                32'h3322_1100, 32'h7766_5544, 32'h0, 32'h0,
                3'd2, 30'h1003, 32'h5544_3322, 1'b0, 128'h0);
        do_read("fill_len1", 32'h6005, 3'd1, 1'b1, 1, 1,
                32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C,
                3'd4, 30'h1800, 32'h0000_0005, 1'b1,
                128'h0F0E0D0C_0B0A0908_07060504_03020100);
        do_read("split_len3", 32'h7002, 3'd3, 1'b0, 0, 0,
                32'hDDCC_BBAA, 32'h1122_3344, 32'h0, 32'h0,
                3'd2, 30'h1C00, 32'h0044_DDCC, 1'b0, 128'h0);

        // Reset after the first beat of a line fill
        bus.read_do        = 1'b1;
        bus.read_address   = 32'h5000;
        bus.read_length    = 3'd4;
        bus.read_cacheable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.read_do = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.avm_readdatavalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", bus.read_ready, 1'b1);
        check("midrst avm_read", bus.avm_read, 1'b0);
        check("midrst done", bus.read_done, 1'b0);
        check("midrst data", bus.read_data, 32'h0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst no_done", bus.read_done, 1'b0);
            check("midrst idle_ready", bus.read_ready, 1'b1);
        end
        do_read("after_rst", 32'h2002, 3'd2, 1'b0, 0, 0,
                32'hA1B2_C3D4, 32'h0, 32'h0, 32'h0,
                3'd1, 30'h800, 32'h0000_A1B2, 1'b0, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
